// File: rtl/turbo_output_packer_if.sv
// Handshake bundle between the turbo encoder pair, the output packer and its consumer.
// master is the packer's view; slave is the upstream/downstream environment's view.
interface turbo_output_packer_if;
    logic in_valid;
    logic in_ready;
    logic xk1;
    logic zk1;
    logic xk2;
    logic zk2;
    logic out_valid;
    logic out_ready;
    logic d0;
    logic d1;
    logic d2;
    logic out_last;

    modport master (
        input  in_valid, xk1, zk1, xk2, zk2, out_ready,
        output in_ready, out_valid, d0, d1, d2, out_last
    );

    modport slave (
        output in_valid, xk1, zk1, xk2, zk2, out_ready,
        input  in_ready, out_valid, d0, d1, d2, out_last
    );
endinterface

// File: rtl/turbo_output_packer.sv
// Packs turbo encoder outputs into rate-1/3 triples d0/d1/d2, then emits 4 reordered tail triples.
// Defining TURBO_BLK_CNT_EN adds a 16-bit completed-block counter output blk_cnt.
module turbo_output_packer #(
    parameter int unsigned LEN_W = 13,
    parameter int unsigned K_MIN = 40,
    parameter int unsigned K_MAX = 6144
) (
    input  logic                  clk,
    input  logic                  aclr,
    input  logic                  start,
    input  logic [LEN_W-1:0]      blk_len,
    turbo_output_packer_if.master bus_io,
    output logic                  busy,
    output logic                  err
`ifdef TURBO_BLK_CNT_EN
    ,
    output logic [15:0]           blk_cnt
`endif
);

    typedef enum logic [1:0] {StIdle, StData, StTailCol, StTailEmit} state_e;

    state_e           state_q, state_d;
    logic [LEN_W-1:0] k_q, k_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [2:0]       tx_q, tx_d, tz_q, tz_d, txp_q, txp_d, tzp_q, tzp_d;
    logic [2:0]       d_q, d_d;
    logic             out_valid_q, out_valid_d;
    logic             out_last_q, out_last_d;
    logic             err_q, err_d;

    logic len_ok, out_free, out_hs, in_ready, in_fire, data_last, tail_last, emit_ok;

    assign len_ok    = (blk_len >= LEN_W'(K_MIN)) && (blk_len <= LEN_W'(K_MAX));
    assign out_hs    = out_valid_q && bus_io.out_ready;
    assign out_free  = !out_valid_q || bus_io.out_ready;
    assign in_fire   = bus_io.in_valid && in_ready;
    assign data_last = (cnt_q == k_q - LEN_W'(1));
    assign tail_last = (cnt_q == LEN_W'(2));
    assign emit_ok   = out_free && (cnt_q < LEN_W'(4));

    // FSM: state register
    always_ff @(posedge clk) begin
        if (aclr) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:     if (start && len_ok) state_d = StData;
            StData:     if (in_fire && data_last) state_d = StTailCol;
            StTailCol:  if (in_fire && tail_last) state_d = StTailEmit;
            StTailEmit: if (out_hs && out_last_q) state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    // FSM: outputs; gated by aclr so nothing is accepted while reset is held
    always_comb begin
        in_ready = 1'b0;
        unique case (state_q)
            StIdle:     in_ready = 1'b0;
            StData:     in_ready = out_free;
            StTailCol:  in_ready = 1'b1;
            StTailEmit: in_ready = 1'b0;
            default:    in_ready = 1'b0;
        endcase
        in_ready = in_ready && !aclr;
        busy     = (state_q != StIdle) && !aclr;
    end

    // Datapath: length/counter, tail store, single-stage output register, error pulse
    always_comb begin
        k_d         = k_q;
        cnt_d       = cnt_q;
        tx_d        = tx_q;
        tz_d        = tz_q;
        txp_d       = txp_q;
        tzp_d       = tzp_q;
        d_d         = d_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q && !bus_io.out_ready;
        err_d       = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start && len_ok) begin
                    k_d   = blk_len;
                    cnt_d = '0;
                end
                // in_valid alongside start is not a violation: start wins
                err_d = (start && !len_ok) || (bus_io.in_valid && !start);
            end
            StData: begin
                err_d = start;
                if (in_fire) begin
                    out_valid_d = 1'b1;
                    out_last_d  = 1'b0;
                    d_d         = {bus_io.xk1, bus_io.zk1, bus_io.zk2};
                    cnt_d       = data_last ? '0 : cnt_q + LEN_W'(1);
                end
            end
            StTailCol: begin
                err_d = start;
                if (in_fire) begin
                    // Shift in from the top so that bit t ends up holding transfer t
                    tx_d  = {bus_io.xk1, tx_q[2:1]};
                    tz_d  = {bus_io.zk1, tz_q[2:1]};
                    txp_d = {bus_io.xk2, txp_q[2:1]};
                    tzp_d = {bus_io.zk2, tzp_q[2:1]};
                    cnt_d = tail_last ? '0 : cnt_q + LEN_W'(1);
                end
            end
            StTailEmit: begin
                err_d = start;
                if (emit_ok) begin
                    out_valid_d = 1'b1;
                    out_last_d  = (cnt_q[1:0] == 2'd3);
                    cnt_d       = cnt_q + LEN_W'(1);
                    unique case (cnt_q[1:0])
                        2'd0:    d_d = {tx_q[0], tz_q[0], tx_q[1]};
                        2'd1:    d_d = {tz_q[1], tx_q[2], tz_q[2]};
                        2'd2:    d_d = {txp_q[0], tzp_q[0], txp_q[1]};
                        default: d_d = {tzp_q[1], txp_q[2], tzp_q[2]};
                    endcase
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (aclr) begin
            k_q         <= '0;
            cnt_q       <= '0;
            tx_q        <= '0;
            tz_q        <= '0;
            txp_q       <= '0;
            tzp_q       <= '0;
            d_q         <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            k_q         <= k_d;
            cnt_q       <= cnt_d;
            tx_q        <= tx_d;
            tz_q        <= tz_d;
            txp_q       <= txp_d;
            tzp_q       <= tzp_d;
            d_q         <= d_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            err_q       <= err_d;
        end
    end

    assign bus_io.in_ready  = in_ready;
    assign bus_io.out_valid = out_valid_q;
    assign bus_io.d0        = d_q[2];
    assign bus_io.d1        = d_q[1];
    assign bus_io.d2        = d_q[0];
    assign bus_io.out_last  = out_last_q;
    assign err              = err_q;

`ifdef TURBO_BLK_CNT_EN
    logic [15:0] blk_cnt_q, blk_cnt_d;

    always_comb begin
        blk_cnt_d = blk_cnt_q;
        if (out_hs && out_last_q) blk_cnt_d = blk_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (aclr) begin
            blk_cnt_q <= '0;
        end else begin
            blk_cnt_q <= blk_cnt_d;
        end
    end

    assign blk_cnt = blk_cnt_q;
`endif

endmodule

// File: tb/tb_turbo_output_packer.sv
// Self-checking bench for turbo_output_packer: legality table, randomized blocks against a
// queue-based stream model, backpressure, error pulses and mid-tail abort.
module tb_turbo_output_packer;
    localparam int unsigned LEN_W = 13;

    logic             clk = 1'b0;
    logic             aclr;
    logic             start;
    logic [LEN_W-1:0] blk_len;
    logic             busy;
    logic             err;
`ifdef TURBO_BLK_CNT_EN
    logic [15:0]      blk_cnt;
`endif
    int unsigned      exp_blk_cnt;
    int               n_checks = 0;
    int               n_pass = 0;

    turbo_output_packer_if bus();

    always #5 clk = ~clk;

    turbo_output_packer #(
        .LEN_W(LEN_W),
        .K_MIN(40),
        .K_MAX(6144)
    ) dut (
        .clk    (clk),
        .aclr   (aclr),
        .start  (start),
        .blk_len(blk_len),
        .bus_io (bus),
        .busy   (busy),
        .err    (err)
`ifdef TURBO_BLK_CNT_EN
        ,
        .blk_cnt(blk_cnt)
`endif
    );

    typedef struct {
        logic [LEN_W-1:0] len;
        bit               legal;
    } len_vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic quiet_inputs();
        start         = 1'b0;
        blk_len       = '0;
        bus.in_valid  = 1'b0;
        bus.xk1       = 1'b0;
        bus.zk1       = 1'b0;
        bus.xk2       = 1'b0;
        bus.zk2       = 1'b0;
        bus.out_ready = 1'b1;
    endtask

    // Holds aclr for one edge, checks the cleared outputs while aclr is still high.
    task automatic do_reset();
        @(negedge clk);
        aclr = 1'b1;
        quiet_inputs();
        @(posedge clk);
        #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_d", {bus.d0, bus.d1, bus.d2, bus.out_last}, 0);
        @(negedge clk);
        aclr = 1'b0;
        exp_blk_cnt = 0;
        #1;
        check("rst_err", err, 0);
    endtask

    // Runs one block of length k. Expected triples come from the stream rules:
    // data triple i = (xk1, zk1, zk2); tail = pairs (x,z) of enc1 then enc2, chunked in threes.
    task automatic run_block(input int k, input int vld_pct, input int rdy_pct, input int stall_at,
                             input int inject_at, input bit abort, input bit fixed);
        logic [3:0] items[$];
        logic [3:0] exp_q[$];
        logic [11:0] tb;
        logic [3:0] it;
        logic [3:0] prev_out;
        int sent, got, cyc, stall_left, budget;
        bit prev_inject, prev_hold, prev_data_xfer, xfer;
        logic [3:0] tail_fix[3];
        tail_fix[0] = 4'b1000;
        tail_fix[1] = 4'b0100;
        tail_fix[2] = 4'b0011;
        for (int i = 0; i < k; i++) begin
            it = fixed ? {3'b100, 1'b1} : 4'($urandom);
            if (fixed) it[1] = 1'($urandom);
            items.push_back(it);
            exp_q.push_back({it[3], it[2], it[0], 1'b0});
        end
        for (int t = 0; t < 3; t++) begin
            it = fixed ? tail_fix[t] : 4'($urandom);
            items.push_back(it);
            tb[11 - 2 * t]     = it[3];
            tb[10 - 2 * t]     = it[2];
            tb[5 - 2 * t]      = it[1];
            tb[4 - 2 * t]      = it[0];
        end
        for (int j = 0; j < 4; j++) begin
            exp_q.push_back({tb[11 - 3 * j], tb[10 - 3 * j], tb[9 - 3 * j], (j == 3) ? 1'b1 : 1'b0});
        end

        // start together with in_valid: the input must not be consumed and no err raised
        @(negedge clk);
        start = 1'b1;
        blk_len = LEN_W'(k);
        bus.in_valid = 1'b1;
        {bus.xk1, bus.zk1, bus.xk2, bus.zk2} = ~items[0];
        @(negedge clk);

        sent = 0; got = 0; cyc = 0; stall_left = 0;
        budget = 50 * (k + 10);
        prev_inject = 0; prev_hold = 0; prev_data_xfer = 0; prev_out = '0;
        while (got < k + 4) begin
            if (cyc > budget) begin
                check("timeout_triples", got, k + 4);
                break;
            end
            if (sent < k + 3) begin
                bus.in_valid = ($urandom_range(99) < vld_pct);
                {bus.xk1, bus.zk1, bus.xk2, bus.zk2} = items[sent];
            end else begin
                bus.in_valid = 1'($urandom);
                {bus.xk1, bus.zk1, bus.xk2, bus.zk2} = 4'($urandom);
            end
            if (cyc == stall_at) stall_left = 5;
            if (stall_left > 0) begin
                bus.out_ready = 1'b0;
                stall_left--;
            end else begin
                bus.out_ready = ($urandom_range(99) < rdy_pct);
            end
            start = (cyc == inject_at);
            blk_len = 13'd40;
            #1;
            check("busy_high", busy, 1);
            check("err", err, prev_inject);
            if (prev_hold) begin
                check("hold_valid", bus.out_valid, 1);
                check("hold_data", {bus.d0, bus.d1, bus.d2, bus.out_last}, prev_out);
            end
            if (prev_data_xfer) check("latency", bus.out_valid, 1);
            if (bus.out_valid && !bus.out_ready && sent > 0 && sent < k)
                check("bp_in_ready", bus.in_ready, 0);
            if (sent >= k && sent < k + 3) check("tail_in_ready", bus.in_ready, 1);
            xfer = bus.in_valid && bus.in_ready;
            prev_data_xfer = xfer && (sent < k);
            if (xfer) sent++;
            if (bus.out_valid && bus.out_ready) begin
                check("triple", {bus.d0, bus.d1, bus.d2, bus.out_last}, exp_q[got]);
                got++;
            end
            prev_hold = bus.out_valid && !bus.out_ready;
            prev_out = {bus.d0, bus.d1, bus.d2, bus.out_last};
            prev_inject = start;
            if (abort && got == k + 1) begin
                @(negedge clk);
                aclr = 1'b1;
                start = 1'b0;
                bus.in_valid = 1'b0;
                @(posedge clk);
                #1;
                check("abort_out_valid", bus.out_valid, 0);
                check("abort_busy", busy, 0);
                check("abort_in_ready", bus.in_ready, 0);
                @(negedge clk);
                aclr = 1'b0;
                exp_blk_cnt = 0;
                #1;
                check("abort_idle_busy", busy, 0);
                check("abort_idle_valid", bus.out_valid, 0);
                return;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        check("triple_count", got, k + 4);
        check("busy_fall", busy, 0);
        check("out_valid_fall", bus.out_valid, 0);
        check("err_end", err, prev_inject);
        exp_blk_cnt++;
`ifdef TURBO_BLK_CNT_EN
        check("blk_cnt", blk_cnt, exp_blk_cnt);
`endif
    endtask

    len_vec_t len_tbl[8];

    initial begin
        len_tbl[0] = '{13'd39, 1'b0};
        len_tbl[1] = '{13'd40, 1'b1};
        len_tbl[2] = '{13'd6144, 1'b1};
        len_tbl[3] = '{13'd6145, 1'b0};
        len_tbl[4] = '{13'd0, 1'b0};
        len_tbl[5] = '{13'd8191, 1'b0};
        len_tbl[6] = '{13'd41, 1'b1};
        len_tbl[7] = '{13'd6143, 1'b1};

        aclr = 1'b1;
        exp_blk_cnt = 0;
        quiet_inputs();
        do_reset();

        // Constant data pattern, fixed tail, full throughput
        run_block(40, 100, 100, -1, -1, 1'b0, 1'b1);
        // Backpressure: out_ready low for 5 cycles mid-DATA
        run_block(60, 100, 100, 20, -1, 1'b0, 1'b0);
        // Randomized handshakes on both sides
        run_block(40, 70, 60, -1, -1, 1'b0, 1'b0);
        run_block(41, 50, 90, -1, -1, 1'b0, 1'b0);
        run_block(257, 80, 40, -1, -1, 1'b0, 1'b0);
        // start while busy: err pulse, stream unaffected
        run_block(50, 80, 80, -1, 15, 1'b0, 1'b0);

        // in_valid in IDLE: one-cycle err pulse
        @(negedge clk);
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        check("idle_in_valid_err", err, 1);
        check("idle_in_valid_busy", busy, 0);
        @(negedge clk);
        #1;
        check("idle_err_pulse_end", err, 0);

        // Length legality table; legal starts are aborted by reset
        foreach (len_tbl[i]) begin
            @(negedge clk);
            start = 1'b1;
            blk_len = len_tbl[i].len;
            @(negedge clk);
            start = 1'b0;
            #1;
            check("len_err", err, !len_tbl[i].legal);
            check("len_busy", busy, len_tbl[i].legal);
            if (len_tbl[i].legal) do_reset();
        end

        // Largest block end to end
        run_block(6144, 100, 100, -1, -1, 1'b0, 1'b0);

        // Abort during tail emission, then a clean block
        run_block(40, 90, 70, -1, -1, 1'b1, 1'b0);
        run_block(40, 90, 70, -1, -1, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
